// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: out-of-order CDB writeback, operand forwarding, mispredict flush, exit halt.
// Optional feature: define ROB_WB_BYPASS_EN to let a head writeback commit in the same cycle.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int ID_W  = 4,
  parameter int REG_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [5:0]       alloc_op,
  input  logic [REG_W-1:0] alloc_dest,
  input  logic [31:0]      alloc_pc,
  output logic [ID_W-1:0]  alloc_id,
  input  logic             wb_valid,
  input  logic [ID_W-1:0]  wb_id,
  input  logic [31:0]      wb_value,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target,
  input  logic [ID_W-1:0]  q1_id,
  input  logic [ID_W-1:0]  q2_id,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_value,
  output logic [31:0]      q2_value,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [ID_W-1:0]  commit_id,
  output logic [REG_W-1:0] commit_dest,
  output logic [31:0]      commit_value,
  output logic [5:0]       commit_op,
  output logic             flush_valid,
  output logic [31:0]      flush_pc,
  output logic             halt_out,
  output logic [ID_W:0]    count
);
  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ISSUED = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [5:0] OP_EXIT   = 6'd39;

  logic [1:0]       state_q [DEPTH];
  logic [1:0]       state_d [DEPTH];
  logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ID_W:0]    count_q, count_d;
  logic             halt_q, halt_d;

  logic [5:0]       op_q     [DEPTH];
  logic [REG_W-1:0] dest_q   [DEPTH];
  logic [31:0]      value_q  [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic             misp_q   [DEPTH];

  logic full, alloc_fire, wb_hit, head_ready, bypass_hit, commit_fire, head_misp;
  logic [31:0] head_value, head_target;

  // The pc is carried by the issue stage but nothing downstream of the ROB consumes it.
  logic unused_pc;
  assign unused_pc = ^alloc_pc;

  assign full        = (count_q == (ID_W+1)'(DEPTH));
  assign alloc_ready = !full && rdy_in;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign wb_hit      = wb_valid && rdy_in && (state_q[wb_id] == ST_ISSUED);
  assign head_ready  = (state_q[head_q] == ST_READY);

`ifdef ROB_WB_BYPASS_EN
  assign bypass_hit = wb_hit && (wb_id == head_q);
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_value  = bypass_hit ? wb_value      : value_q[head_q];
  assign head_misp   = bypass_hit ? wb_mispredict : misp_q[head_q];
  assign head_target = bypass_hit ? wb_target     : target_q[head_q];

  assign commit_valid = (head_ready || bypass_hit) && !halt_q && rdy_in;
  assign commit_fire  = commit_valid && commit_ready;
  assign commit_id    = commit_valid ? head_q : '0;
  assign commit_dest  = commit_valid ? dest_q[head_q] : '0;
  assign commit_value = commit_valid ? head_value : 32'h0;
  assign commit_op    = commit_valid ? op_q[head_q] : 6'h0;
  assign flush_valid  = commit_fire && head_misp;
  assign flush_pc     = flush_valid ? head_target : 32'h0;

  assign halt_out = halt_q;
  assign count    = count_q;
  assign alloc_id = tail_q;

  logic [ID_W-1:0] q_id  [2];
  logic            q_rdy [2];
  logic [31:0]     q_val [2];
  assign q_id[0] = q1_id;
  assign q_id[1] = q2_id;

  // A result on the CDB is visible to queries before it lands in the entry.
  for (genvar gi = 0; gi < 2; gi++) begin : g_query
    logic fwd;
    assign fwd       = wb_valid && (wb_id == q_id[gi]);
    assign q_rdy[gi] = fwd || (state_q[q_id[gi]] == ST_READY);
    assign q_val[gi] = fwd ? wb_value :
                       ((state_q[q_id[gi]] == ST_READY) ? value_q[q_id[gi]] : 32'h0);
  end
  assign q1_ready = q_rdy[0];
  assign q2_ready = q_rdy[1];
  assign q1_value = q_val[0];
  assign q2_value = q_val[1];

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    halt_d  = halt_q;
    if (wb_hit) state_d[wb_id] = ST_READY;
    if (alloc_fire) begin
      state_d[tail_q] = ST_ISSUED;
      tail_d          = tail_q + ID_W'(1);
    end
    if (commit_fire) begin
      state_d[head_q] = ST_FREE;
      head_d          = head_q + ID_W'(1);
      if (op_q[head_q] == OP_EXIT) halt_d = 1'b1;
    end
    count_d = count_q + (ID_W+1)'(alloc_fire) - (ID_W+1)'(commit_fire);
    // Mispredict squashes everything younger, including this cycle's alloc and writeback.
    if (flush_valid) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = ST_FREE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      halt_q  <= halt_d;
    end
  end

  // Payload is only observed while its entry is live, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (alloc_fire) begin
      op_q[tail_q]   <= alloc_op;
      dest_q[tail_q] <= alloc_dest;
      misp_q[tail_q] <= 1'b0;
    end
    if (wb_hit) begin
      value_q[wb_id]  <= wb_value;
      misp_q[wb_id]   <= wb_mispredict;
      target_q[wb_id] <= wb_target;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer at DEPTH=4; follows ROB_WB_BYPASS_EN for bypass timing.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        alloc_valid, alloc_ready;
  logic [5:0]  alloc_op;
  logic [4:0]  alloc_dest;
  logic [31:0] alloc_pc;
  logic [1:0]  alloc_id;
  logic        wb_valid, wb_mispredict;
  logic [1:0]  wb_id;
  logic [31:0] wb_value, wb_target;
  logic [1:0]  q1_id, q2_id;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_valid, commit_ready;
  logic [1:0]  commit_id;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic [5:0]  commit_op;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        halt_out;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.DEPTH(4), .ID_W(2), .REG_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_dest(alloc_dest), .alloc_pc(alloc_pc), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_id(commit_id),
    .commit_dest(commit_dest), .commit_value(commit_value), .commit_op(commit_op),
    .flush_valid(flush_valid), .flush_pc(flush_pc), .halt_out(halt_out), .count(count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; alloc_op = 0; alloc_dest = 0; alloc_pc = 0;
    wb_valid = 0; wb_id = 0; wb_value = 0; wb_mispredict = 0; wb_target = 0;
    q1_id = 0; q2_id = 0; commit_ready = 0; rdy_in = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_in = 0;
    #2;
    rst_in = 1;
  endtask

  task automatic alloc_n(input int n, input logic [5:0] op_base);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1; alloc_op = op_base + 6'(i); alloc_dest = 5'(i + 1); alloc_pc = 32'(i * 4);
      tick();
    end
    alloc_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_in = 0;
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid: got %b expected 0", commit_valid); end
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt_out); end
    checks++; if (alloc_id !== 2'd0) begin errors++; $display("FAIL reset_alloc_id: got %0d expected 0", alloc_id); end
    tick();
    rst_in = 1;
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1; alloc_op = 6'(i); alloc_dest = 5'(i + 1); alloc_pc = 32'(i * 4);
      #1;
      checks++; if (alloc_id !== 2'(i)) begin errors++; $display("FAIL fill_alloc_id: got %0d expected %0d", alloc_id, i); end
      tick();
    end
    alloc_valid = 0;
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_alloc_ready: got %b expected 0", alloc_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    wb_valid = 1; wb_id = 0; wb_value = 32'h100;
    tick();
    wb_valid = 0;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL fill_commit_valid: got %b expected 1", commit_valid); end
    checks++; if (commit_value !== 32'h100) begin errors++; $display("FAIL fill_commit_value: got %h expected 100", commit_value); end
    checks++; if (commit_dest !== 5'd1) begin errors++; $display("FAIL fill_commit_dest: got %0d expected 1", commit_dest); end
    commit_ready = 1;
    tick();
    commit_ready = 0;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_count_after_commit: got %0d expected 3", count); end
    alloc_valid = 1; alloc_op = 6'd5; alloc_dest = 5'd7;
    #1;
    checks++; if (alloc_id !== 2'd0) begin errors++; $display("FAIL wrap_alloc_id: got %0d expected 0", alloc_id); end
    tick();
    alloc_valid = 0;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", count); end
  endtask

  task automatic test_out_of_order();
    logic [1:0] wb_order [3];
    wb_order[0] = 2'd2; wb_order[1] = 2'd1; wb_order[2] = 2'd0;
    do_reset();
    alloc_n(3, 6'd10);
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_id = wb_order[k]; wb_value = 32'h11 * 32'(wb_order[k]);
      tick();
    end
    wb_valid = 0;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL ooo_commit_valid: got %b expected 1", commit_valid); end
    commit_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (commit_id !== 2'(i)) begin errors++; $display("FAIL ooo_commit_id: got %0d expected %0d", commit_id, i); end
      checks++; if (commit_value !== 32'h11 * 32'(i)) begin errors++; $display("FAIL ooo_commit_value: got %h expected %h", commit_value, 32'h11 * 32'(i)); end
      checks++; if (commit_op !== 6'(10 + i)) begin errors++; $display("FAIL ooo_commit_op: got %0d expected %0d", commit_op, 10 + i); end
      tick();
    end
    commit_ready = 0;
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained_valid: got %b expected 0", commit_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ooo_drained_count: got %0d expected 0", count); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_n(2, 6'd1);
    wb_valid = 1; wb_id = 1; wb_value = 32'h8; wb_mispredict = 1; wb_target = 32'h1000;
    tick();
    wb_id = 0; wb_value = 32'h4; wb_mispredict = 0; wb_target = 32'h0;
    tick();
    wb_valid = 0;
    alloc_n(2, 6'd3);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL misp_count_full: got %0d expected 4", count); end
    commit_ready = 1;
    #1;
    checks++; if (flush_valid !== 1'b0) begin errors++; $display("FAIL misp_no_flush_id0: got %b expected 0", flush_valid); end
    tick();
    alloc_valid = 1; alloc_op = 6'd9;
    wb_valid = 1; wb_id = 2; wb_value = 32'h99;
    #1;
    checks++; if (commit_id !== 2'd1) begin errors++; $display("FAIL misp_commit_id: got %0d expected 1", commit_id); end
    checks++; if (flush_valid !== 1'b1) begin errors++; $display("FAIL misp_flush_valid: got %b expected 1", flush_valid); end
    checks++; if (flush_pc !== 32'h1000) begin errors++; $display("FAIL misp_flush_pc: got %h expected 1000", flush_pc); end
    tick();
    alloc_valid = 0; wb_valid = 0; commit_ready = 0; q1_id = 2;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL misp_count_after: got %0d expected 0", count); end
    checks++; if (alloc_id !== 2'd0) begin errors++; $display("FAIL misp_alloc_id_after: got %0d expected 0", alloc_id); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL misp_alloc_ready_after: got %b expected 1", alloc_ready); end
    checks++; if (q1_ready !== 1'b0) begin errors++; $display("FAIL misp_squashed_wb: got %b expected 0", q1_ready); end
  endtask

  task automatic test_query_forward();
    do_reset();
    alloc_n(4, 6'd0);
    q1_id = 3; q2_id = 1;
    wb_valid = 1; wb_id = 3; wb_value = 32'hABCD;
    #1;
    checks++; if (q1_ready !== 1'b1) begin errors++; $display("FAIL fwd_q1_ready: got %b expected 1", q1_ready); end
    checks++; if (q1_value !== 32'hABCD) begin errors++; $display("FAIL fwd_q1_value: got %h expected abcd", q1_value); end
    checks++; if (q2_ready !== 1'b0) begin errors++; $display("FAIL fwd_q2_not_ready: got %b expected 0", q2_ready); end
    tick();
    wb_valid = 0; q2_id = 3;
    #1;
    checks++; if (q2_ready !== 1'b1) begin errors++; $display("FAIL stored_q2_ready: got %b expected 1", q2_ready); end
    checks++; if (q2_value !== 32'hABCD) begin errors++; $display("FAIL stored_q2_value: got %h expected abcd", q2_value); end
  endtask

  task automatic test_rdy_stall();
    do_reset();
    alloc_n(1, 6'd2);
    wb_valid = 1; wb_id = 0; wb_value = 32'h77;
    tick();
    wb_valid = 0;
    rdy_in = 0; commit_ready = 1; alloc_valid = 1;
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL stall_commit_valid: got %b expected 0", commit_valid); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL stall_alloc_ready: got %b expected 0", alloc_ready); end
    tick(); tick(); tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", count); end
    checks++; if (alloc_id !== 2'd1) begin errors++; $display("FAIL stall_tail: got %0d expected 1", alloc_id); end
    rdy_in = 1; alloc_valid = 0; commit_ready = 0;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL stall_resume_valid: got %b expected 1", commit_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    alloc_valid = 1; alloc_op = 6'd39; alloc_dest = 5'd0;
    tick();
    alloc_op = 6'd3; alloc_dest = 5'd2;
    tick();
    alloc_valid = 0;
    wb_valid = 1; wb_id = 0; wb_value = 32'h1;
    tick();
    wb_id = 1; wb_value = 32'h2;
    tick();
    wb_valid = 0; commit_ready = 1;
    #1;
    checks++; if (commit_op !== 6'd39) begin errors++; $display("FAIL halt_commit_op: got %0d expected 39", commit_op); end
    tick();
    checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halt_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL halt_count: got %0d expected 1", count); end
    tick(); tick();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL halt_blocks_commit: got %b expected 0", commit_valid); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL halt_count_held: got %0d expected 1", count); end
    rst_in = 0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", count); end
    checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL midreset_halt: got %b expected 0", halt_out); end
    rst_in = 1; commit_ready = 0;
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_n(1, 6'd4);
    wb_valid = 1; wb_id = 0; wb_value = 32'h55; commit_ready = 1;
    #1;
`ifdef ROB_WB_BYPASS_EN
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL bypass_same_cycle: got %b expected 1", commit_valid); end
    checks++; if (commit_value !== 32'h55) begin errors++; $display("FAIL bypass_value: got %h expected 55", commit_value); end
    tick();
    wb_valid = 0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", count); end
`else
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle: got %b expected 0", commit_valid); end
    tick();
    wb_valid = 0;
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL nobypass_next_cycle: got %b expected 1", commit_valid); end
    checks++; if (commit_value !== 32'h55) begin errors++; $display("FAIL nobypass_value: got %h expected 55", commit_value); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL nobypass_count: got %0d expected 0", count); end
`endif
    commit_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_out_of_order();
    test_mispredict();
    test_query_forward();
    test_rdy_stall();
    test_halt();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
